// File: rtl/pipe_pkg.sv
// Shared pipeline encodings for memory operations, branch types and the
// EX/MEM stage register, plus small decode helpers used by the MEM stage.
package pipe_pkg;

    // Memory operation encoding driven by decode/EX.
    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    // Conditional branch encoding.
    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } br_type_e;

    // Access size class derived from the memory op.
    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_B    = 2'd1,
        SZ_H    = 2'd2,
        SZ_W    = 2'd3
    } acc_size_e;

    // Contents of the EX/MEM pipeline register; every stage output is a field.
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  byte_en;
        logic [31:0] wdata;
        logic        read;
        logic        write;
        logic [1:0]  byte_off;
        logic [3:0]  ld_type;
        logic [31:0] wb_result;
        logic [4:0]  wb_dest;
        logic        wb_reg_write;
        logic        br_taken;
        logic [31:0] br_pc;
        logic        misalign;
    } ex_mem_t;

    // Unused encodings (9-15) collapse to "no memory access".
    function automatic logic [3:0] norm_op(input logic [3:0] op);
        logic [3:0] r;
        r = (op > OP_SW) ? OP_NONE : op;
        return r;
    endfunction

    function automatic acc_size_e op_size(input logic [3:0] op);
        acc_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_B;
            OP_LH, OP_LHU, OP_SH: sz = SZ_H;
            OP_LW, OP_SW:         sz = SZ_W;
            default:              sz = SZ_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    // Halfwords need an even offset, words a zero offset; bytes always fit.
    function automatic logic misaligned(input acc_size_e sz, input logic [1:0] off);
        logic m;
        case (sz)
            SZ_H:    m = off[0];
            SZ_W:    m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_align.sv
// Byte-lane enable and store-data replication for a single memory access.
// Purely combinational; the enclosing stage registers the results.
module store_align
    import pipe_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] rt_data,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata
);

    acc_size_e sz;

    assign sz = op_size(op);

    // Select lane mask by access size and replicate the store operand so
    // the byte/halfword lands on whichever lanes the mask selects.
    always_comb begin
        byte_en = 4'b0000;
        wdata   = rt_data;
        case (sz)
            SZ_B: begin
                byte_en = 4'b0001 << off;
                wdata   = {4{rt_data[7:0]}};
            end
            SZ_H: begin
                byte_en = 4'b0011 << off;
                wdata   = {2{rt_data[15:0]}};
            end
            SZ_W: begin
                byte_en = 4'b1111;
                wdata   = rt_data;
            end
            default: begin
                byte_en = 4'b0000;
                wdata   = rt_data;
            end
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures the EX result, forms memory strobes,
// byte lanes and store data, resolves branches into a one-cycle redirect
// pulse, and flags misaligned accesses. Holds under mem_stall.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              flush,
    input  logic              mem_stall,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [3:0]        mem_op,
    input  logic [1:0]        br_type,
    input  logic [DATA_W-1:0] br_target,
    input  logic [4:0]        dest_reg,
    input  logic              reg_write,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_addr,
    output logic [3:0]        mem_byte_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_byte_off,
    output logic [3:0]        mem_ld_type,
    output logic [DATA_W-1:0] wb_result,
    output logic [4:0]        wb_dest,
    output logic              wb_reg_write,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_pc,
    output logic              misalign_exc
);

    ex_mem_t    st;
    ex_mem_t    nxt;
    logic [3:0] op_n;
    acc_size_e  sz;
    logic       mis;
    logic       br_hit;
    logic       capture;
    logic [3:0] lane_en;
    logic [31:0] lane_data;

    assign op_n    = norm_op(mem_op);
    assign sz      = op_size(op_n);
    assign mis     = misaligned(sz, alu_result[1:0]);
    assign br_hit  = ((br_type == BR_EQ) &&  alu_zero) ||
                     ((br_type == BR_NE) && !alu_zero);

    // A held instruction blocks EX only while memory is stalling.
    assign ex_ready = !st.valid || !mem_stall;
    assign capture  = ex_valid && ex_ready && !flush;

    store_align u_store_align (
        .op      (op_n),
        .off     (alu_result[1:0]),
        .rt_data (rt_data),
        .byte_en (lane_en),
        .wdata   (lane_data)
    );

    // Build the value the stage register takes on a capture edge; a
    // misaligned access still retires as valid but with every side effect
    // suppressed so the exception path can handle it.
    always_comb begin
        nxt              = '0;
        nxt.valid        = 1'b1;
        nxt.addr         = {alu_result[31:2], 2'b00};
        nxt.byte_en      = lane_en;
        nxt.wdata        = lane_data;
        nxt.read         = is_load(op_n)  && !mis;
        nxt.write        = is_store(op_n) && !mis;
        nxt.byte_off     = alu_result[1:0];
        nxt.ld_type      = op_n;
        nxt.wb_result    = alu_result;
        nxt.wb_dest      = dest_reg;
        nxt.wb_reg_write = reg_write && (dest_reg != 5'd0) && !mis;
        nxt.br_taken     = br_hit;
        nxt.br_pc        = br_target;
        nxt.misalign     = mis;
    end

    // Stage register: reset beats everything; capture loads; flush or an
    // empty EX slot leaves a bubble; a stall holds all but the redirect pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= '0;
        end else if (capture) begin
            st <= nxt;
        end else if (flush || ex_ready) begin
            st.valid        <= 1'b0;
            st.read         <= 1'b0;
            st.write        <= 1'b0;
            st.byte_en      <= 4'b0000;
            st.wb_reg_write <= 1'b0;
            st.br_taken     <= 1'b0;
            st.misalign     <= 1'b0;
        end else begin
            st.br_taken     <= 1'b0;
        end
    end

    assign mem_valid    = st.valid;
    assign mem_addr     = st.addr;
    assign mem_byte_en  = st.byte_en;
    assign mem_wdata    = st.wdata;
    assign mem_read     = st.read;
    assign mem_write    = st.write;
    assign mem_byte_off = st.byte_off;
    assign mem_ld_type  = st.ld_type;
    assign wb_result    = st.wb_result;
    assign wb_dest      = st.wb_dest;
    assign wb_reg_write = st.wb_reg_write;
    assign br_taken     = st.br_taken;
    assign br_pc        = st.br_pc;
    assign misalign_exc = st.misalign;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a vector table of single-cycle captures
// followed by hand-written stall, flush and reset sequences.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst, ex_valid, flush, mem_stall, alu_zero, reg_write;
    logic [31:0] alu_result, rt_data, br_target;
    logic [3:0]  mem_op;
    logic [1:0]  br_type;
    logic [4:0]  dest_reg;
    logic        ex_ready, mem_valid, mem_read, mem_write, wb_reg_write, br_taken, misalign_exc;
    logic [31:0] mem_addr, mem_wdata, wb_result, br_pc;
    logic [3:0]  mem_byte_en, mem_ld_type;
    logic [1:0]  mem_byte_off;
    logic [4:0]  wb_dest;

    int tests = 0;
    int fails = 0;

    ex_mem_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .flush(flush), .mem_stall(mem_stall), .alu_result(alu_result),
        .alu_zero(alu_zero), .rt_data(rt_data), .mem_op(mem_op),
        .br_type(br_type), .br_target(br_target), .dest_reg(dest_reg),
        .reg_write(reg_write), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_off(mem_byte_off),
        .mem_ld_type(mem_ld_type), .wb_result(wb_result), .wb_dest(wb_dest),
        .wb_reg_write(wb_reg_write), .br_taken(br_taken), .br_pc(br_pc),
        .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  br;
        logic [31:0] alu;
        logic        z;
        logic [31:0] rt;
        logic [31:0] tgt;
        logic [4:0]  dst;
        logic        rw;
        logic [31:0] e_addr;
        logic [1:0]  e_off;
        logic [3:0]  e_ld;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_rd, e_wr, e_wbre, e_brt, e_mis;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [148:0] outs();
        return {mem_valid, mem_addr, mem_byte_off, mem_ld_type, mem_byte_en,
                mem_wdata, mem_read, mem_write, wb_result, wb_dest,
                wb_reg_write, br_taken, br_pc, misalign_exc};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        mem_op = v.op; br_type = v.br; alu_result = v.alu; alu_zero = v.z;
        rt_data = v.rt; br_target = v.tgt; dest_reg = v.dst; reg_write = v.rw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic [148:0] held;

        //           op     br  alu           z  rt            tgt    dst rw  addr          off ld  be    wdata         rd wr wb bt ms
        vecs[0]  = '{4'd8,  0, 32'h100,      0, 32'hDEADBEEF, 32'h0,  0, 0, 32'h100,      0, 8, 4'hF, 32'hDEADBEEF, 0, 1, 0, 0, 0};
        vecs[1]  = '{4'd6,  0, 32'h103,      0, 32'h000000AB, 32'h0,  0, 0, 32'h100,      3, 6, 4'h8, 32'hABABABAB, 0, 1, 0, 0, 0};
        vecs[2]  = '{4'd5,  0, 32'h102,      0, 32'h11223344, 32'h0,  5, 1, 32'h100,      2, 5, 4'hF, 32'h11223344, 0, 0, 0, 0, 1};
        vecs[3]  = '{4'd5,  0, 32'h200,      0, 32'h0,        32'h0,  5, 1, 32'h200,      0, 5, 4'hF, 32'h0,        1, 0, 1, 0, 0};
        vecs[4]  = '{4'd3,  0, 32'h202,      0, 32'h1234,     32'h0,  3, 1, 32'h200,      2, 3, 4'hC, 32'h12341234, 1, 0, 1, 0, 0};
        vecs[5]  = '{4'd4,  0, 32'h201,      0, 32'h0,        32'h0,  3, 1, 32'h200,      1, 4, 4'h6, 32'h0,        0, 0, 0, 0, 1};
        vecs[6]  = '{4'd7,  0, 32'h302,      0, 32'hCAFE5678, 32'h0,  0, 0, 32'h300,      2, 7, 4'hC, 32'h56785678, 0, 1, 0, 0, 0};
        vecs[7]  = '{4'd7,  0, 32'h303,      0, 32'hCAFE5678, 32'h0,  0, 0, 32'h300,      3, 7, 4'h8, 32'h56785678, 0, 0, 0, 0, 1};
        vecs[8]  = '{4'd1,  0, 32'h401,      0, 32'h99,       32'h0,  7, 1, 32'h400,      1, 1, 4'h2, 32'h99999999, 1, 0, 1, 0, 0};
        vecs[9]  = '{4'd2,  0, 32'h402,      0, 32'h0,        32'h0,  0, 1, 32'h400,      2, 2, 4'h4, 32'h0,        1, 0, 0, 0, 0};
        vecs[10] = '{4'd0,  0, 32'h55,       0, 32'h77,       32'h0,  9, 1, 32'h54,       1, 0, 4'h0, 32'h77,       0, 0, 1, 0, 0};
        vecs[11] = '{4'd12, 0, 32'h1000,     0, 32'hFFFFFFFF, 32'h0,  2, 1, 32'h1000,     0, 0, 4'h0, 32'hFFFFFFFF, 0, 0, 1, 0, 0};
        vecs[12] = '{4'd0,  1, 32'h0,        1, 32'h0,        32'h40, 0, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 0, 1, 0};
        vecs[13] = '{4'd0,  2, 32'h0,        1, 32'h0,        32'h44, 0, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 0, 0, 0};
        vecs[14] = '{4'd0,  2, 32'h5,        0, 32'h0,        32'h80, 0, 0, 32'h4,        1, 0, 4'h0, 32'h0,        0, 0, 0, 1, 0};
        vecs[15] = '{4'd0,  1, 32'h7,        0, 32'h0,        32'hC0, 0, 0, 32'h4,        3, 0, 4'h0, 32'h0,        0, 0, 0, 0, 0};
        vecs[16] = '{4'd8,  0, 32'h101,      0, 32'h1,        32'h0,  4, 1, 32'h100,      1, 8, 4'hF, 32'h1,        0, 0, 0, 0, 1};

        rst = 1'b1; ex_valid = 1'b1; flush = 1'b0; mem_stall = 1'b0;
        drive(vecs[0]);

        // Reset overrides a pending capture.
        tick(); tick();
        chk("reset_outputs", outs(), 149'd0);
        chk("reset_ex_ready", ex_ready, 1);

        // Table: back-to-back captures, no stalls.
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            v = vecs[i];
            drive(v);
            ex_valid = 1'b1;
            tick();
            chk($sformatf("vec%0d", i), outs(),
                {1'b1, v.e_addr, v.e_off, v.e_ld, v.e_be, v.e_wd, v.e_rd, v.e_wr,
                 v.alu, v.dst, v.e_wbre, v.e_brt, v.tgt, v.e_mis});
            @(negedge clk);
        end

        // Bubble: nothing valid from EX.
        ex_valid = 1'b0; drive(vecs[3]);
        tick();
        chk("bubble_strobes", {mem_valid, mem_read, mem_write, wb_reg_write, mem_byte_en}, 8'h00);

        // Branch redirect pulses once, then stall holds everything else.
        @(negedge clk);
        drive(vecs[12]); ex_valid = 1'b1;
        tick();
        chk("beq_taken", {br_taken, br_pc}, {1'b1, 32'h40});
        held = outs();
        @(negedge clk);
        mem_stall = 1'b1; drive(vecs[0]);
        #1;
        chk("stall_ex_ready", ex_ready, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall_hold%0d", c), outs(), {held[148:34], 1'b0, held[32:0]});
            chk($sformatf("stall_ready%0d", c), ex_ready, 0);
            @(negedge clk);
        end

        // Flush while stalled drops the held instruction.
        flush = 1'b1; ex_valid = 1'b1;
        tick();
        chk("flush_stalled", {mem_valid, mem_read, mem_write, wb_reg_write, br_taken}, 5'b0);
        chk("flush_ready", ex_ready, 1);

        // Flush on an otherwise clean capture also yields a bubble.
        @(negedge clk);
        mem_stall = 1'b0; drive(vecs[3]);
        tick();
        chk("flush_capture", {mem_valid, mem_read, wb_reg_write}, 3'b0);

        // Capture a store, stall it, then reset mid-stall.
        @(negedge clk);
        flush = 1'b0; drive(vecs[0]);
        tick();
        chk("pre_rst_write", {mem_valid, mem_write}, 2'b11);
        @(negedge clk);
        mem_stall = 1'b1;
        tick();
        chk("stall_keeps_store", {mem_valid, mem_write, mem_addr}, {2'b11, 32'h100});
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst_mid_stall", outs(), 149'd0);
        chk("rst_mid_stall_ready", ex_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard ceiling so the run cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, default 32: datapath width; only 32 is supported.
REQ-002 Clocking SHALL be one clock, clk, with a synchronous, active-high reset, rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ex_valid  in  1  EX holds a valid instruction.
REQ-006 ex_ready  out  1  stage accepts the instruction this cycle.
REQ-007 flush  in  1  kill the instruction being captured and any held instruction.
REQ-008 mem_stall  in  1  memory not accepting; hold outputs.
REQ-009 alu_result  in  32  ALU result; effective address for loads/stores.
REQ-010 alu_zero  in  1  ALU zero flag.
REQ-011 rt_data  in  32  store source data.
REQ-012 mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW.
REQ-013 br_type  in  2  0 none, 1 BEQ, 2 BNE.
REQ-014 br_target  in  32  branch target PC.
REQ-015 dest_reg  in  5  writeback register; reg_write  in  1  writeback enable.
REQ-016 mem_valid  out  1  registered instruction valid.
REQ-017 mem_addr  out  32  alu_result with bits [1:0] cleared.
REQ-018 mem_byte_en  out  4  byte lanes; mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_read, mem_write  out  1 each  access strobes; mem_byte_off  out  2  alu_result[1:0]; mem_ld_type  out  4  registered mem_op, for WB extraction.
REQ-020 wb_result  out  32  registered alu_result; wb_dest  out  5; wb_reg_write  out  1.
REQ-021 br_taken  out  1  one-cycle redirect pulse; br_pc  out  32  redirect target.
REQ-022 misalign_exc  out  1  address-misalignment exception.

Function
REQ-023 ex_ready SHALL equal !mem_valid || !mem_stall (combinational).
REQ-024 Capture SHALL occur on the rising edge when ex_valid && ex_ready && !flush; all outputs register with 1-cycle latency.
REQ-025 With mem_valid && mem_stall, all outputs except br_taken SHALL hold.
REQ-026 When flush=1, mem_valid and all strobes SHALL be 0 next cycle, regardless of stall or capture.
REQ-027 With ex_valid=0 and ex_ready=1, next-cycle mem_valid SHALL be 0 (bubble).
REQ-028 Byte enables: SB = 4'b0001 << off; SH = 4'b0011 << off; SW = 4'b1111; loads use the same mask by size; none = 0.
REQ-029 mem_wdata: SB replicates rt_data[7:0] ×4; SH replicates rt_data[15:0] ×2; SW passes rt_data.
REQ-030 Misaligned (LH/LHU/SH with off[0]=1; LW/SW with off≠0): misalign_exc=1; mem_read, mem_write, wb_reg_write=0; mem_valid=1.
REQ-031 mem_read SHALL be 1 for ops 1-5; mem_write for ops 6-8; both are gated by validity and misalignment.
REQ-032 br_taken SHALL be 1 for exactly the cycle after capture when (BEQ && alu_zero) || (BNE && !alu_zero), with br_pc = br_target, and SHALL NOT repeat during stall.
REQ-033 Writes to register 0 SHALL force wb_reg_write to 0.
REQ-034 mem_op values 9-15 SHALL be treated as none.

Reset
REQ-035 On rst, all outputs SHALL be 0 next edge; rst overrides flush and capture.
REQ-036 rst asserted mid-stall SHALL discard the held instruction.

Structure
REQ-037 mem_op and br_type encodings SHALL live in a shared package, pipe_pkg.
REQ-038 Byte-enable and store-data lane generation SHALL be one sub-module, store_align (combinational).

Verification
REQ-039 SW, alu_result=0x100, rt_data=0xDEADBEEF -> next cycle mem_addr=0x100, byte_en=1111, wdata=0xDEADBEEF, mem_write=1.
REQ-040 SB, alu_result=0x103, rt_data=0x000000AB -> byte_en=1000, wdata=0xABABABAB, mem_byte_off=3.
REQ-041 LW, alu_result=0x102 -> misalign_exc=1, mem_read=0, wb_reg_write=0, mem_valid=1.
REQ-042 BEQ, alu_zero=1, br_target=0x40, then mem_stall held 3 cycles -> br_taken=1 for one cycle only; ex_ready=0 during the stall.
REQ-043 ex_valid=1 with flush=1 while stalled -> mem_valid=0 next cycle; rst mid-stall -> all outputs 0.
